// File: rtl/automata_stage_pkg.sv
// Shared types and helpers for the automata stage report collector.
package automata_stage_pkg;

    // Widest report vector the lowest-set-bit helper can scan.
    localparam int unsigned MAX_RPT   = 256;
    localparam int unsigned LSB_IDX_W = $clog2(MAX_RPT);

    // Default cluster geometry.
    localparam int unsigned DEF_NUM_AUT     = 13;
    localparam int unsigned DEF_RPT_PER_AUT = 4;
    localparam int unsigned DEF_TS_W        = 32;
    localparam int unsigned NUM_RPT         = DEF_NUM_AUT * DEF_RPT_PER_AUT;
    localparam int unsigned ID_W            = $clog2(NUM_RPT);

    // One delivered event for the default geometry.
    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [DEF_TS_W-1:0] ts;
    } rpt_evt_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    function automatic int unsigned calc_num_rpt(input int unsigned num_aut,
                                                 input int unsigned rpt_per_aut);
        return num_aut * rpt_per_aut;
    endfunction

    function automatic int unsigned calc_id_w(input int unsigned num_rpt);
        return (num_rpt > 1) ? $clog2(num_rpt) : 1;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [LSB_IDX_W-1:0] lowest_set(input logic [MAX_RPT-1:0] v);
        logic [LSB_IDX_W-1:0] idx;
        logic                 found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_RPT; i++) begin
            if (!found && v[i]) begin
                idx   = LSB_IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rpt_evt_fifo.sv
// Synchronous event FIFO with flush and a registered head word.
module rpt_evt_fifo #(
    parameter int unsigned W     = 38,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             valid_q;
    logic [W-1:0]     data_q, head_d;
    logic             rd_ok, wr_ok;

    assign full_o     = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = !valid_q;
    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;
    assign rd_ok      = rd_en_i && valid_q;
    assign wr_ok      = wr_en_i && (!full_o || rd_ok);

    // Next read pointer, occupancy, and the word that will sit at the head;
    // a write into an otherwise empty queue bypasses straight to the head.
    always_comb begin
        rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        head_d = (wr_ok && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= (cnt_d != '0);
            data_q   <= head_d;
        end
    end

endmodule

// File: rtl/automata_stage_report_collector.sv
// Symbol pass-through pipeline plus report collection: sticky flags and a
// time-stamped (report id, symbol index) event stream.
module automata_stage_report_collector
    import automata_stage_pkg::*;
#(
    parameter int unsigned SYM_W       = 8,
    parameter int unsigned NUM_AUT     = 13,
    parameter int unsigned RPT_PER_AUT = 4,
    parameter int unsigned PIPE_DEPTH  = 1,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TS_W        = 32,
    localparam int unsigned NUM_RPT    = calc_num_rpt(NUM_AUT, RPT_PER_AUT),
    localparam int unsigned ID_W       = calc_id_w(NUM_RPT)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_run,
    input  logic [SYM_W-1:0]   in_symbols,
    input  logic               in_restart,
    output logic               out_run,
    output logic [SYM_W-1:0]   out_symbols,
    output logic               out_restart,
    input  logic               aut_rpt_valid,
    input  logic [NUM_RPT-1:0] aut_reports,
    input  logic               clear_sticky,
    output logic [NUM_RPT-1:0] sticky,
    output logic               any_report,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic [TS_W-1:0]    evt_ts,
    output logic [15:0]        merge_cnt
);

    logic [PIPE_DEPTH-1:0] run_q, rst_q, run_in, rst_in;
    logic [SYM_W-1:0]      sym_q [PIPE_DEPTH];
    logic [SYM_W-1:0]      sym_in [PIPE_DEPTH];

    logic [TS_W-1:0]    ts_q;
    logic [NUM_RPT-1:0] hit, sticky_q;
    drain_state_e       state_q, state_d;
    logic [NUM_RPT-1:0] snap_vec_q, snap_vec_d, bl_vec_q, bl_vec_d, pick_oh;
    logic [TS_W-1:0]    snap_ts_q, snap_ts_d, bl_ts_q, bl_ts_d;
    logic [ID_W-1:0]    pick_id;
    logic [15:0]        merge_cnt_q;
    logic               merge_inc, push;
    logic               fifo_full, fifo_empty, fifo_pop, fifo_can_push;
    logic [ID_W+TS_W-1:0] fifo_rd_data;

    // Stage inputs: stage 0 takes the ports, later stages chain.
    always_comb begin
        run_in    = '0;
        rst_in    = '0;
        run_in[0] = in_run;
        rst_in[0] = in_restart;
        sym_in[0] = in_symbols;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            run_in[i] = run_q[i-1];
            rst_in[i] = rst_q[i-1];
            sym_in[i] = sym_q[i-1];
        end
    end

    // Pass-through registers; a symbol only advances alongside its run bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= '0;
            rst_q <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) sym_q[i] <= '0;
        end else begin
            run_q <= run_in;
            rst_q <= rst_in;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                if (run_in[i]) sym_q[i] <= sym_in[i];
            end
        end
    end

    assign out_run     = run_q[PIPE_DEPTH-1];
    assign out_restart = rst_q[PIPE_DEPTH-1];
    assign out_symbols = sym_q[PIPE_DEPTH-1];

    // Symbol-index timestamp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        ts_q <= '0;
        else if (in_restart) ts_q <= '0;
        else if (in_run)     ts_q <= ts_q + TS_W'(1);
    end

    assign hit = aut_rpt_valid ? aut_reports : '0;

    // Sticky flags; a hit coincident with clear survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          sticky_q <= '0;
        else if (in_restart)   sticky_q <= '0;
        else if (clear_sticky) sticky_q <= hit;
        else                   sticky_q <= sticky_q | hit;
    end

    assign sticky     = sticky_q;
    assign any_report = |sticky_q;

    assign pick_id       = ID_W'(lowest_set(MAX_RPT'(snap_vec_q)));
    assign pick_oh       = NUM_RPT'(1) << pick_id;
    assign fifo_pop      = evt_ready && !fifo_empty;
    assign fifo_can_push = !fifo_full || fifo_pop;

    // Drain FSM: snapshot drains one bit per cycle; hits arriving meanwhile
    // accumulate in the backlog, which is folded in (including a same-cycle
    // hit) when the snapshot empties.
    always_comb begin
        state_d    = state_q;
        snap_vec_d = snap_vec_q;
        snap_ts_d  = snap_ts_q;
        bl_vec_d   = bl_vec_q;
        bl_ts_d    = bl_ts_q;
        merge_inc  = 1'b0;
        push       = 1'b0;
        if (in_restart) begin
            state_d    = ST_IDLE;
            snap_vec_d = '0;
            snap_ts_d  = '0;
            bl_vec_d   = '0;
            bl_ts_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hit != '0) begin
                        snap_vec_d = hit;
                        snap_ts_d  = ts_q;
                        state_d    = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (hit != '0) begin
                        bl_vec_d = bl_vec_q | hit;
                        if (bl_vec_q == '0) bl_ts_d   = ts_q;
                        else                merge_inc = 1'b1;
                    end
                    if (fifo_can_push) begin
                        push       = 1'b1;
                        snap_vec_d = snap_vec_q & ~pick_oh;
                        if (snap_vec_d == '0) begin
                            if (bl_vec_d != '0) begin
                                snap_vec_d = bl_vec_d;
                                snap_ts_d  = bl_ts_d;
                                bl_vec_d   = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Drain FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            snap_vec_q <= '0;
            snap_ts_q  <= '0;
            bl_vec_q   <= '0;
            bl_ts_q    <= '0;
        end else begin
            state_q    <= state_d;
            snap_vec_q <= snap_vec_d;
            snap_ts_q  <= snap_ts_d;
            bl_vec_q   <= bl_vec_d;
            bl_ts_q    <= bl_ts_d;
        end
    end

    // Saturating backlog-merge counter; survives restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              merge_cnt_q <= '0;
        else if (merge_inc && merge_cnt_q != '1)   merge_cnt_q <= merge_cnt_q + 16'd1;
    end

    assign merge_cnt = merge_cnt_q;

    rpt_evt_fifo #(
        .W     (ID_W + TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .flush_i    (in_restart),
        .wr_en_i    (push),
        .wr_data_i  ({pick_id, snap_ts_q}),
        .rd_en_i    (fifo_pop),
        .rd_valid_o (evt_valid),
        .rd_data_o  (fifo_rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign evt_id = fifo_rd_data[ID_W+TS_W-1:TS_W];
    assign evt_ts = fifo_rd_data[TS_W-1:0];

endmodule

// File: tb/tb_automata_stage_report_collector.sv
// Randomised bench for automata_stage_report_collector against a queue-based
// reference model; a second instance with a 4-bit timestamp shares the stimulus.
module tb_automata_stage_report_collector;
    import automata_stage_pkg::*;

    localparam int unsigned NR = 52;
    localparam int unsigned PD = 1;
    localparam int unsigned FD = 16;

    logic          clk = 1'b0;
    logic          reset_n, in_run, in_restart, aut_rpt_valid, clear_sticky, evt_ready;
    logic [7:0]    in_symbols;
    logic [NR-1:0] aut_reports;

    logic          out_run, out_restart, any_report, evt_valid;
    logic [7:0]    out_symbols;
    logic [NR-1:0] sticky;
    logic [5:0]    evt_id;
    logic [31:0]   evt_ts;
    logic [15:0]   merge_cnt;

    logic          out_run_w, out_restart_w, any_report_w, evt_valid_w;
    logic [7:0]    out_symbols_w;
    logic [NR-1:0] sticky_w;
    logic [5:0]    evt_id_w;
    logic [3:0]    evt_ts_w;
    logic [15:0]   merge_cnt_w;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    automata_stage_report_collector #(
        .SYM_W(8), .NUM_AUT(13), .RPT_PER_AUT(4), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD), .TS_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_run(in_run), .in_symbols(in_symbols),
        .in_restart(in_restart), .out_run(out_run), .out_symbols(out_symbols),
        .out_restart(out_restart), .aut_rpt_valid(aut_rpt_valid), .aut_reports(aut_reports),
        .clear_sticky(clear_sticky), .sticky(sticky), .any_report(any_report),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_ts(evt_ts),
        .merge_cnt(merge_cnt)
    );

    automata_stage_report_collector #(
        .SYM_W(8), .NUM_AUT(13), .RPT_PER_AUT(4), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD), .TS_W(4)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .in_run(in_run), .in_symbols(in_symbols),
        .in_restart(in_restart), .out_run(out_run_w), .out_symbols(out_symbols_w),
        .out_restart(out_restart_w), .aut_rpt_valid(aut_rpt_valid), .aut_reports(aut_reports),
        .clear_sticky(clear_sticky), .sticky(sticky_w), .any_report(any_report_w),
        .evt_valid(evt_valid_w), .evt_ready(evt_ready), .evt_id(evt_id_w), .evt_ts(evt_ts_w),
        .merge_cnt(merge_cnt_w)
    );

    // ---------------- reference model ----------------
    typedef struct { logic run; logic [7:0] sym; logic rst; } pipe_t;

    rpt_evt_t      m_fifo[$];
    int            m_snap[$];     // report ids still to deliver from the current batch
    logic [31:0]   m_snap_ts;
    logic [NR-1:0] m_bl;
    logic [31:0]   m_bl_ts;
    logic [31:0]   m_ts;
    logic [NR-1:0] m_sticky;
    int unsigned   m_merge;
    pipe_t         m_hist[$];
    logic [7:0]    m_osym;

    task automatic model_reset();
        pipe_t z;
        z.run = 1'b0; z.sym = '0; z.rst = 1'b0;
        m_fifo.delete(); m_snap.delete(); m_hist.delete();
        for (int i = 0; i < PD; i++) m_hist.push_back(z);
        m_snap_ts = '0; m_bl = '0; m_bl_ts = '0; m_ts = '0;
        m_sticky = '0; m_merge = 0; m_osym = '0;
    endtask

    task automatic load_batch(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) m_snap.push_back(i);
    endtask

    task automatic model_step();
        pipe_t         e;
        rpt_evt_t      ev;
        logic [NR-1:0] hit;
        int            sz;
        bit            pop;
        e.run = in_run; e.sym = in_symbols; e.rst = in_restart;
        m_hist.push_back(e);
        e = m_hist.pop_front();
        if (m_hist[0].run) m_osym = m_hist[0].sym;

        hit = aut_rpt_valid ? aut_reports : '0;
        sz  = m_fifo.size();
        pop = (sz > 0) && evt_ready;
        if (in_restart) begin
            m_ts = '0; m_sticky = '0; m_bl = '0;
            m_snap.delete(); m_fifo.delete();
            return;
        end
        m_sticky = clear_sticky ? hit : (m_sticky | hit);
        if (pop) ev = m_fifo.pop_front();
        if (m_snap.size() > 0) begin
            if (hit != '0) begin
                if (m_bl != '0) begin
                    if (m_merge < 65535) m_merge++;
                end else begin
                    m_bl_ts = m_ts;
                end
                m_bl = m_bl | hit;
            end
            if (sz < FD || pop) begin
                ev.id = 6'(m_snap.pop_front());
                ev.ts = m_snap_ts;
                m_fifo.push_back(ev);
                if (m_snap.size() == 0 && m_bl != '0) begin
                    load_batch(m_bl);
                    m_snap_ts = m_bl_ts;
                    m_bl = '0;
                end
            end
        end else if (hit != '0) begin
            load_batch(hit);
            m_snap_ts = m_ts;
        end
        if (in_run) m_ts = m_ts + 32'd1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] ets;
        chk("evt_valid", evt_valid, m_fifo.size() != 0);
        chk("evt_valid_w", evt_valid_w, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            ets = m_fifo[0].ts;
            chk("evt_id", evt_id, m_fifo[0].id);
            chk("evt_ts", evt_ts, ets);
            chk("evt_id_w", evt_id_w, m_fifo[0].id);
            chk("evt_ts_w", evt_ts_w, ets[3:0]);
        end
        chk("sticky", sticky, m_sticky);
        chk("sticky_w", sticky_w, m_sticky);
        chk("any_report", any_report, |m_sticky);
        chk("merge_cnt", merge_cnt, m_merge);
        chk("merge_cnt_w", merge_cnt_w, m_merge);
        chk("out_run", out_run, m_hist[0].run);
        chk("out_restart", out_restart, m_hist[0].rst);
        chk("out_symbols", out_symbols, m_osym);
        chk("out_symbols_w", out_symbols_w, m_osym);
        chk("any_report_w", any_report_w, |m_sticky);
        chk("out_run_w", out_run_w, m_hist[0].run);
        chk("out_restart_w", out_restart_w, m_hist[0].rst);
    endtask

    // Inputs are changed only at posedge+1, after this returns.
    task automatic step();
        if (reset_n) model_step();
        else         model_reset();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        in_run = 1'b0; in_restart = 1'b0; aut_rpt_valid = 1'b0;
        aut_reports = '0; clear_sticky = 1'b0;
    endtask

    task automatic restart_once();
        quiet(); in_restart = 1'b1; step(); in_restart = 1'b0;
    endtask

    task automatic hit_bits(input int a, input int b, input int c);
        aut_reports = '0;
        if (a >= 0) aut_reports[a] = 1'b1;
        if (b >= 0) aut_reports[b] = 1'b1;
        if (c >= 0) aut_reports[c] = 1'b1;
        aut_rpt_valid = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]    last_sym;
        logic [NR-1:0] seen;
        int unsigned   rdy_pct;

        reset_n = 1'b0; evt_ready = 1'b1; in_symbols = '0; quiet();
        model_reset();
        step(); step();
        reset_n = 1'b1;

        // 1: reset mid-stream, then symbol pass-through
        for (int i = 0; i < 4; i++) begin
            in_run = 1'b1; in_symbols = 8'($urandom); hit_bits(i, -1, -1); step();
        end
        quiet();
        reset_n = 1'b0;
        #2;
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_out_run", out_run, 0);
        chk("rst_out_symbols", out_symbols, 0);
        chk("rst_merge_cnt", merge_cnt, 0);
        step(); step();
        reset_n = 1'b1;
        last_sym = '0;
        for (int i = 0; i < 5; i++) begin
            in_run = 1'b1; in_symbols = 8'($urandom); last_sym = in_symbols; step();
        end
        chk("sym_pass", out_symbols, last_sym);
        quiet(); step();
        chk("sym_hold", out_symbols, last_sym);

        // 2: single hit bit 9 at ts=3
        restart_once();
        for (int i = 0; i < 3; i++) begin in_run = 1'b1; step(); end
        quiet(); hit_bits(9, -1, -1); step();
        quiet();
        chk("single_sticky9", sticky[9], 1);
        chk("single_any", any_report, 1);
        chk("single_early", evt_valid, 0);
        step();
        chk("single_valid", evt_valid, 1);
        chk("single_id", evt_id, 9);
        chk("single_ts", evt_ts, 3);
        step();

        // 3: multi-hit {2,7,40} at ts=10
        restart_once();
        for (int i = 0; i < 10; i++) begin in_run = 1'b1; step(); end
        quiet(); hit_bits(40, 2, 7); step();
        quiet(); step();
        chk("multi_id0", evt_id, 2);
        chk("multi_ts0", evt_ts, 10);
        step();
        chk("multi_id1", evt_id, 7);
        step();
        chk("multi_id2", evt_id, 40);
        chk("multi_ts2", evt_ts, 10);
        step();
        chk("multi_done", evt_valid, 0);

        // 4: backpressure, 20 single hits into a 16-deep FIFO
        restart_once();
        evt_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            quiet(); in_run = 1'b1; hit_bits(i, -1, -1); step();
        end
        quiet(); step(); step();
        chk("bp_merged", merge_cnt != 0, 1);
        evt_ready = 1'b1;
        seen = '0;
        for (int k = 0; k < 60; k++) begin
            if (evt_valid) seen[evt_id] = 1'b1;
            step();
        end
        chk("bp_all_ids", seen, 52'hFFFFF);
        chk("bp_drained", evt_valid, 0);

        // 5: restart while draining, with a coincident hit on bit 5
        evt_ready = 1'b0;
        quiet(); in_run = 1'b1; hit_bits(1, 3, 20); step();
        quiet(); step();
        in_restart = 1'b1; hit_bits(5, -1, -1); step();
        quiet(); evt_ready = 1'b1;
        chk("rs_valid0", evt_valid, 0);
        chk("rs_sticky0", sticky, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rs_no_evt", evt_valid, 0);
        end
        hit_bits(11, -1, -1); step();
        quiet(); step();
        chk("rs_id", evt_id, 11);
        chk("rs_ts0", evt_ts, 0);
        step();

        // 6: sticky clear race, then 4-bit timestamp wrap
        hit_bits(4, 30, -1); step();
        quiet(); clear_sticky = 1'b1; hit_bits(0, -1, -1); step();
        quiet();
        chk("race_sticky", sticky, 52'h1);
        for (int k = 0; k < 6; k++) step();
        restart_once();
        for (int i = 0; i < 17; i++) begin in_run = 1'b1; step(); end
        quiet(); hit_bits(3, -1, -1); step();
        quiet(); step();
        chk("wrap_ts_w", evt_ts_w, 1);
        chk("wrap_ts", evt_ts, 17);
        step();

        // Random traffic with alternating backpressure regimes.
        rdy_pct = 90;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = (rdy_pct == 90) ? 20 : 90;
            in_run        = ($urandom_range(0, 1) == 1);
            in_symbols    = 8'($urandom);
            in_restart    = ($urandom_range(0, 99) < 2);
            aut_rpt_valid = ($urandom_range(0, 99) < 35);
            aut_reports   = '0;
            for (int b = $urandom_range(0, 3); b > 0; b--)
                aut_reports[$urandom_range(0, NR-1)] = 1'b1;
            clear_sticky  = ($urandom_range(0, 99) < 5);
            evt_ready     = ($urandom_range(0, 99) < rdy_pct);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
